// File: rtl/pipelined_cla_subtractor_pkg.sv
// Shared widths and pipeline register layouts for the borrow-lookahead subtractor.
package pipelined_cla_subtractor_pkg;
  localparam int WIDTH   = 16;
  localparam int GROUP   = 4;
  localparam int NGROUPS = 4;

  typedef struct packed {
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               bin;
    logic [WIDTH-1:0]   g;
    logic [WIDTH-1:0]   p;
    logic [NGROUPS-1:0] g_star;
    logic [NGROUPS-1:0] p_star;
  } s1_t;

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic             bout;
    logic             v;
  } s2_t;
endpackage

// File: rtl/pipelined_cla_subtractor_block_borrow_lookahead_unit.sv
// Four-wide borrow lookahead: group generate/propagate and the three internal borrows.
module block_borrow_lookahead_unit
  import pipelined_cla_subtractor_pkg::*;
(
  input  logic [GROUP-1:0] g,
  input  logic [GROUP-1:0] p,
  input  logic             bin,
  output logic             g_star,
  output logic             p_star,
  output logic [3:1]       b
);
  always_comb begin
    b[1]   = g[0] | (p[0] & bin);
    b[2]   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bin);
    b[3]   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & bin);
    g_star = g[3] | (g[2] & p[3]) | (g[1] & p[2] & p[3]) | (g[0] & p[1] & p[2] & p[3]);
    p_star = &p;
  end
endmodule

// File: rtl/pipelined_cla_subtractor.sv
// Two-stage 16-bit subtractor D = A - B - Bin with valid/ready on both sides.
module pipelined_cla_subtractor
  import pipelined_cla_subtractor_pkg::*;
(
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             V,
  output logic             out_valid,
  input  logic             out_ready
);
  s1_t  s1_q, s1_d;
  s2_t  s2_q, s2_d;
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic s2_take;

  logic [WIDTH-1:0]           g_bit, p_bit;
  logic [NGROUPS-1:0]         g_star_s1, p_star_s1;
  logic [3*NGROUPS-1:0]       s1_b_unused;
  logic                       grp_g, grp_p;
  logic [3:1]                 grp_b;
  logic [NGROUPS-1:0]         grp_bin;
  logic [3*NGROUPS-1:0]       s2_bb;
  logic [NGROUPS-1:0]         s2_gs_unused, s2_ps_unused;
  logic [WIDTH-1:0]           bor;
  logic [WIDTH-1:0]           diff;

  assign s2_take   = ~s2_valid_q | out_ready;
  assign in_ready  = ~s1_valid_q | s2_take;
  assign out_valid = s2_valid_q;
  assign D         = s2_q.d;
  assign Bout      = s2_q.bout;
  assign V         = s2_q.v;

  assign g_bit = ~A & B;
  assign p_bit = ~(A ^ B);

  // Stage 1 only needs group G*/P*; the in-group borrows are rebuilt in stage 2.
  for (genvar j = 0; j < NGROUPS; j++) begin : g_s1_grp
    block_borrow_lookahead_unit u_bblu (
      .g      (g_bit[j*GROUP +: GROUP]),
      .p      (p_bit[j*GROUP +: GROUP]),
      .bin    (1'b0),
      .g_star (g_star_s1[j]),
      .p_star (p_star_s1[j]),
      .b      (s1_b_unused[j*3 +: 3])
    );
  end

  always_comb begin
    s1_d       = s1_q;
    s1_valid_d = s1_valid_q;
    if (in_ready) begin
      s1_valid_d    = in_valid;
      s1_d.a        = A;
      s1_d.b        = B;
      s1_d.bin      = Bin;
      s1_d.g        = g_bit;
      s1_d.p        = p_bit;
      s1_d.g_star   = g_star_s1;
      s1_d.p_star   = p_star_s1;
    end
  end

  block_borrow_lookahead_unit u_bblu_top (
    .g      (s1_q.g_star),
    .p      (s1_q.p_star),
    .bin    (s1_q.bin),
    .g_star (grp_g),
    .p_star (grp_p),
    .b      (grp_b)
  );

  assign grp_bin = {grp_b, s1_q.bin};

  for (genvar j = 0; j < NGROUPS; j++) begin : g_s2_bit
    block_borrow_lookahead_unit u_bblu (
      .g      (s1_q.g[j*GROUP +: GROUP]),
      .p      (s1_q.p[j*GROUP +: GROUP]),
      .bin    (grp_bin[j]),
      .g_star (s2_gs_unused[j]),
      .p_star (s2_ps_unused[j]),
      .b      (s2_bb[j*3 +: 3])
    );
  end

  always_comb begin
    bor = '0;
    for (int j = 0; j < NGROUPS; j++) begin
      bor[j*GROUP]              = grp_bin[j];
      bor[j*GROUP+1 +: GROUP-1] = s2_bb[j*(GROUP-1) +: GROUP-1];
    end
    diff = s1_q.a ^ s1_q.b ^ bor;
  end

  always_comb begin
    s2_d       = s2_q;
    s2_valid_d = s2_valid_q;
    if (s2_take) begin
      s2_valid_d = s1_valid_q;
      s2_d.d     = diff;
      s2_d.bout  = grp_g | (grp_p & s1_q.bin);
      s2_d.v     = (s1_q.a[WIDTH-1] ^ s1_q.b[WIDTH-1]) & (diff[WIDTH-1] ^ s1_q.a[WIDTH-1]);
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      s1_q       <= '0;
      s1_valid_q <= 1'b0;
      s2_q       <= '0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s1_valid_q <= s1_valid_d;
      s2_q       <= s2_d;
      s2_valid_q <= s2_valid_d;
    end
  end
endmodule

// File: tb/tb_pipelined_cla_subtractor.sv
// Self-checking bench: arithmetic reference model plus scoreboard of accepted operands.
module tb_pipelined_cla_subtractor;
  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic [15:0] A = '0, B = '0;
  logic        Bin = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] D;
  logic        Bout, V, out_valid;
  logic        out_ready = 1'b0;

  int checks = 0;
  int failures = 0;
  int take_cnt = 0;
  logic [17:0] q[$];
  logic        stall_prev = 1'b0;
  logic [17:0] hold;

  pipelined_cla_subtractor dut (
    .Clk(Clk), .Rst_n(Rst_n), .A(A), .B(B), .Bin(Bin),
    .in_valid(in_valid), .in_ready(in_ready),
    .D(D), .Bout(Bout), .V(V), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 Clk = ~Clk;

  // returns {bout, v, d}
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b, input logic bi);
    int ud, sd;
    logic [15:0] d;
    ud = int'(a) - int'(b) - int'(bi);
    sd = int'($signed(a)) - int'($signed(b)) - int'(bi);
    d  = ud[15:0];
    return {(ud < 0), (sd > 32767 || sd < -32768), d};
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (!Rst_n) begin
      q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        check("stall_hold", {13'd0, out_valid, Bout, V, D}, {13'd0, 1'b1, hold});
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("extra_result", 32'(q.size()), 32'd1);
        else check("result", {14'd0, Bout, V, D}, {14'd0, q.pop_front()});
        take_cnt++;
      end
      if (in_valid && in_ready) q.push_back(model(A, B, Bin));
      stall_prev = out_valid && !out_ready;
      hold = {Bout, V, D};
    end
  end

  task automatic send_check(input logic [15:0] a, input logic [15:0] b, input logic bi,
                            input logic [15:0] ed, input logic eb, input logic ev, input string nm);
    @(posedge Clk); #1;
    A = a; B = b; Bin = bi; in_valid = 1'b1; out_ready = 1'b1;
    check({nm, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge Clk); #1;
    in_valid = 1'b0;
    check({nm, "_lat_early"}, 32'(out_valid), 32'd0);
    @(posedge Clk); #1;
    check({nm, "_lat_valid"}, 32'(out_valid), 32'd1);
    check({nm, "_d"}, 32'(D), 32'(ed));
    check({nm, "_bv"}, {30'd0, Bout, V}, {30'd0, eb, ev});
  endtask

  task automatic drain(input string nm);
    int n;
    in_valid = 1'b0; out_ready = 1'b1;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 50) begin @(posedge Clk); #1; n++; end
    check({nm, "_drained"}, 32'(q.size()), 32'd0);
  endtask

  initial begin
    int t0, zero_rdy;
    logic [15:0] cap;

    check("model_1", 32'(model(16'h1234, 16'h0234, 1'b0)), {14'd0, 2'b00, 16'h1000});
    check("model_2", 32'(model(16'h0000, 16'h0001, 1'b0)), {14'd0, 2'b10, 16'hFFFF});
    check("model_3", 32'(model(16'h8000, 16'h0001, 1'b0)), {14'd0, 2'b01, 16'h7FFF});
    check("model_4", 32'(model(16'hFFFF, 16'hFFFF, 1'b1)), {14'd0, 2'b10, 16'hFFFF});

    #2;
    check("rst_state", {12'd0, out_valid, Bout, V, in_ready, D}, {12'd0, 3'b000, 1'b1, 16'h0000});
    #21 Rst_n = 1'b1;
    #1 check("post_rst_in_ready", 32'(in_ready), 32'd1);

    send_check(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, "dir_1234");
    send_check(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, "dir_borrow");
    send_check(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, "dir_ovf");
    send_check(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, "dir_chain");
    send_check(16'h0010, 16'h000F, 1'b1, 16'h0000, 1'b0, 1'b0, "dir_zero");
    drain("dir");

    // back-to-back
    t0 = take_cnt; zero_rdy = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge Clk); #1;
      A = 16'($urandom); B = 16'($urandom); Bin = 1'($urandom);
      in_valid = 1'b1; out_ready = 1'b1;
      if (!in_ready) zero_rdy++;
    end
    @(posedge Clk); #1; in_valid = 1'b0;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    check("b2b_in_ready_drops", 32'(zero_rdy), 32'd0);
    check("b2b_results", 32'(take_cnt - t0), 32'd1000);
    drain("b2b");

    // backpressure
    @(posedge Clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; A = 16'($urandom); B = 16'($urandom); Bin = 1'($urandom);
    @(posedge Clk); #1;
    A = 16'($urandom); B = 16'($urandom); Bin = 1'($urandom);
    @(posedge Clk); #1;
    cap = D;
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      A = 16'($urandom); B = 16'($urandom); Bin = 1'($urandom);
      @(posedge Clk); #1;
      check("bp_in_ready_held", 32'(in_ready), 32'd0);
      check("bp_d_stable", 32'(D), 32'(cap));
      check("bp_entries", 32'(q.size()), 32'd2);
    end
    t0 = take_cnt;
    drain("bp");
    check("bp_drain_count", 32'(take_cnt - t0), 32'd2);

    // random valid/ready
    for (int i = 0; i < 2000; i++) begin
      @(posedge Clk); #1;
      A = 16'($urandom); B = 16'($urandom); Bin = 1'($urandom);
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
    end
    drain("rnd");

    // reset with both stages full
    @(posedge Clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; A = 16'hAAAA; B = 16'h1111; Bin = 1'b0;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    check("rst_pre_full", 32'(q.size()), 32'd2);
    #2 Rst_n = 1'b0;
    #1;
    check("rst_mid_state", {13'd0, out_valid, Bout, V, D}, 32'd0);
    check("rst_mid_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    @(posedge Clk); #3 Rst_n = 1'b1;
    send_check(16'h0010, 16'h000F, 1'b1, 16'h0000, 1'b0, 1'b0, "post_rst");
    drain("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pipelined_cla_subtractor.md
# pipelined_cla_subtractor

Two-stage pipelined 16-bit subtractor computing D = A − B − Bin with a two-level borrow-lookahead network, the subtract-direction counterpart to the lab's carry-lookahead adder. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. It sustains one subtraction per cycle and exposes borrow-out and signed overflow.

## Interface
- WIDTH, 16: operand width; fixed at 16, four 4-bit lookahead groups.
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  asynchronous, active-low reset.
- A  input  16  minuend.
- B  input  16  subtrahend.
- Bin  input  1  borrow-in.
- in_valid  input  1  A/B/Bin are valid.
- in_ready  output  1  block accepts the operands this cycle.
- D  output  16  difference A − B − Bin, modulo 2^16.
- Bout  output  1  borrow-out: 1 when A < B + Bin, unsigned.
- V  output  1  two's-complement overflow of A − B − Bin.
- out_valid  output  1  D/Bout/V are valid.
- out_ready  input  1  consumer takes the result this cycle.

## Operation
- Bit terms: g_i = ~A_i & B_i (borrow generate), p_i = ~(A_i ^ B_i) (borrow propagate).
- Borrow chain: b_0 = Bin; b_{i+1} = g_i | p_i & b_i; D_i = A_i ^ B_i ^ b_i.
- Group level: per 4-bit group j, G*_j = g3 | g2·p3 | g1·p2·p3 | g0·p1·p2·p3 and P*_j = p0·p1·p2·p3, with in-group borrows b1..b3 computed the same way as carry lookahead.
- Second level: a lookahead over (G*_j, P*_j, Bin) yields the group borrow-ins b_4, b_8, b_12 and Bout = b_16.
- V = (A15 ^ B15) & (D15 ^ A15).
- Stage 1 (S1) registers A, B, Bin, g[15:0], p[15:0], G*[3:0] and P*[3:0], plus s1_valid.
- Stage 2 (S2) computes the group borrows, bit borrows, D, Bout and V from the S1 registers and registers them, plus s2_valid. out_valid = s2_valid.
- Flow control:
  - s2_take = ~s2_valid | out_ready
  - in_ready = ~s1_valid | s2_take
  - S1 loads when in_ready; s1_valid ← in_valid.
  - S2 loads when s2_take; s2_valid ← s1_valid.
- No bubbles are inserted: a full pipeline with out_ready held high accepts an input every cycle.

## Timing
- Reset (Rst_n low, asynchronous): s1_valid = s2_valid = 0 and every data register clears to 0, so D = 0, Bout = 0, V = 0, out_valid = 0.
- in_ready = 1 during and immediately after reset.
- Latency: an operand accepted at edge k appears with out_valid = 1 after edge k+1, assuming no stall.
- Throughput: one result per cycle.
- Stall: while out_valid & ~out_ready, D/Bout/V stay bit-stable. S1 may fill one further entry; in_ready then drops to 0.
- Simultaneous events: out_ready & in_valid with both stages full advance both stages and accept the new input in the same cycle. No data is lost or duplicated.
- in_valid = 0 with in_ready = 1 loads a bubble (s1_valid ← 0); the data registers may update.
- Reset mid-operation discards both in-flight entries. The first post-reset result comes only from an input accepted after Rst_n deasserts.
- Combinational paths: in_ready depends on out_ready. There is no path from A/B/Bin to any output.

## Structure
- A shared package/header holds WIDTH = 16, GROUP = 4 and NGROUPS = 4.
- One sub-module, block_borrow_lookahead_unit: inputs g[3:0], p[3:0], bin; outputs G*, P*, b[3:1].
  - It is instantiated four times at bit level (group terms in S1, in-group borrows in S2).
  - It is instantiated once at group level in S2.

## Test plan
- A = 0x1234, B = 0x0234, Bin = 0 → D = 0x1000, Bout = 0, V = 0, out_valid two edges after acceptance.
- A = 0x0000, B = 0x0001, Bin = 0 → D = 0xFFFF, Bout = 1, V = 0. Then A = 0x8000, B = 0x0001 → D = 0x7FFF, Bout = 0, V = 1.
- Full propagate chain: A = 0xFFFF, B = 0xFFFF, Bin = 1 → D = 0xFFFF, Bout = 1, V = 0. Also A = 0x0010, B = 0x000F, Bin = 1 → D = 0x0000, Bout = 0.
- Back-to-back 1000 random operands with out_ready = 1 → one result per cycle, in order, matching a scoreboard of {A − B − Bin}.
- Backpressure: out_ready = 0 for 5 cycles while in_valid = 1 →
  - two entries held, in_ready = 0 from the second stalled cycle;
  - D stable throughout;
  - on release, results drain in order with no loss or duplication.
- Assert Rst_n = 0 for 1 cycle with both stages full → out_valid = 0 immediately, D = 0; next result corresponds to the first post-reset input.
